alu_lockstep_cmp: RTL

Parametrised dual-lane lockstep ALU checker, successor to the 4-bit dual ALU/XOR compare macro. Two identical WIDTH-bit ALU lanes run in a 2-stage pipeline with a valid qualifier. Each beat produces both results and their bitwise XOR difference. Mismatches feed a saturating error counter, a sticky fault flag and a threshold interrupt, so the user project can raise `user_irq` on lockstep divergence instead of relying on an external pin check.

---
 rtl/alu_lockstep_pkg.sv | 17 +
 rtl/alu_lane.sv | 38 +++
 rtl/alu_lockstep_cmp.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alu_lockstep_pkg.sv
// Shared opcode definitions for the dual-lane lockstep ALU checker.
package alu_lockstep_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

endpackage

// File: rtl/alu_lane.sv
// Combinational WIDTH-bit ALU lane: one result plus a carry/borrow flag.
module alu_lane
  import alu_lockstep_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              sel,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    result = '0;
    carry  = 1'b0;
    case (sel)
      OP_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
      // Bit WIDTH of the widened difference is set exactly when a < b.
      OP_SUB:  {carry, result} = {1'b0, a} - {1'b0, b};
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        carry  = a[0];
      end
      OP_PASS: result = a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_lockstep_cmp.sv
// Two lockstep ALU lanes in a 2-stage pipeline with XOR compare, saturating
// mismatch counter, sticky fault flag and threshold interrupt.
module alu_lockstep_cmp
  import alu_lockstep_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int CNT_W  = 8,
  parameter int THRESH = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] b0_i,
  input  logic [OP_W-1:0]  sel0_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b1_i,
  input  logic [OP_W-1:0]  sel1_i,
  input  logic             clr_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] alu_out0_o,
  output logic [WIDTH-1:0] alu_out1_o,
  output logic             carry0_o,
  output logic             carry1_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             carry_diff_o,
  output logic             mismatch_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             fault_o,
  output logic             irq_o
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam bit               THRESH_EN = (THRESH > 0) &&
                                           (longint'(THRESH) <= ((longint'(1) << CNT_W) - 1));
  localparam logic [CNT_W-1:0] THRESH_M1 = THRESH_EN ? CNT_W'(THRESH - 1) : '0;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a0, s1_b0, s1_a1, s1_b1;
  op_e              s1_sel0, s1_sel1;

  logic [WIDTH-1:0] res0, res1;
  logic             cy0, cy1;
  logic             beat_mismatch;
  logic             count_inc;
  logic             thresh_hit;

  // Stage 1: capture operands, opcodes and valid.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      s1_valid <= 1'b0;
      s1_a0    <= '0;
      s1_b0    <= '0;
      s1_a1    <= '0;
      s1_b1    <= '0;
      s1_sel0  <= OP_ADD;
      s1_sel1  <= OP_ADD;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      s1_valid <= in_valid_i;
      s1_a0    <= a0_i;
      s1_b0    <= b0_i;
      s1_a1    <= a1_i;
      s1_b1    <= b1_i;
      s1_sel0  <= op_e'(sel0_i);
      s1_sel1  <= op_e'(sel1_i);
    end
  end

  alu_lane #(.WIDTH(WIDTH)) u_lane0 (
    .a      (s1_a0),
    .b      (s1_b0),
    .sel    (s1_sel0),
    .result (res0),
    .carry  (cy0)
  );

  alu_lane #(.WIDTH(WIDTH)) u_lane1 (
    .a      (s1_a1),
    .b      (s1_b1),
    .sel    (s1_sel1),
    .result (res1),
    .carry  (cy1)
  );

  // The counter reacts to the beat being registered, so the count already
  // includes the beat presented on the same edge.
  assign beat_mismatch = s1_valid && ((res0 != res1) || (cy0 != cy1));
  assign count_inc     = beat_mismatch && !clr_i && (err_cnt_o != CNT_MAX);
  assign thresh_hit    = THRESH_EN && count_inc && (err_cnt_o == THRESH_M1);

  // Stage 2: results hold their last value while no beat is presented.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      out_valid_o  <= 1'b0;
      alu_out0_o   <= '0;
      alu_out1_o   <= '0;
      carry0_o     <= 1'b0;
      carry1_o     <= 1'b0;
      diff_o       <= '0;
      carry_diff_o <= 1'b0;
    end else begin
      out_valid_o <= s1_valid;
      if (s1_valid) begin
        alu_out0_o   <= res0;
        alu_out1_o   <= res1;
        carry0_o     <= cy0;
        carry1_o     <= cy1;
        diff_o       <= res0 ^ res1;
        carry_diff_o <= cy0 ^ cy1;
      end
    end
  end

  assign mismatch_o = out_valid_o & ((|diff_o) | carry_diff_o);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      err_cnt_o <= '0;
      fault_o   <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      irq_o <= thresh_hit;
      if (clr_i) begin
        err_cnt_o <= '0;
        fault_o   <= 1'b0;
      end else begin
        if (count_inc) err_cnt_o <= err_cnt_o + 1'b1;
        if (thresh_hit) fault_o <= 1'b1;
      end
    end
  end

endmodule
